// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//
// Holds the fetch PC and issues pipelined word-aligned requests to instruction
// memory over a valid/ready request channel. Responses arrive in order and
// cannot be back-pressured. Returned instructions are buffered in a DEPTH-entry
// FIFO together with their PC and PC+4. A redirect flushes the FIFO and marks
// every in-flight request as stale, so its response is dropped on arrival.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   PCReset          synchronous active-high reset
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request
//   imem_req_addr    fetch address (word-aligned)
//   imem_resp_valid  in-order response valid
//   imem_resp_data   returned instruction
//   redirect         branch/jump taken, load redirect_pc
//   redirect_pc      new PC, bits [1:0] forced to zero
//   instr_valid      FIFO head valid
//   instr_ready      consumer accepts the head entry
//   instr            head instruction
//   instr_pc         PC of the head instruction
//   instr_incr_pc    instr_pc + 4 (wrapping)
module fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               PCReset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  instr_incr_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Occupancy sum is kept two bits wider than a counter so it never wraps.
  localparam logic [CW+1:0] DEPTH_C = (CW+2)'(DEPTH);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  slot_pc    [DEPTH];
  logic [INSTR_W-1:0] slot_instr [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] rd_ptr;

  logic [CW-1:0] live;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;

  logic [CW+1:0] occupancy;
  logic          credit;
  logic          req_fire;
  logic          resp_drop;
  logic          resp_fill;
  logic          pop;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign occupancy = (CW+2)'(count) + (CW+2)'(live) + (CW+2)'(drop);
  assign credit    = occupancy < DEPTH_C;

  assign imem_req_valid = !PCReset && !redirect && credit;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Stale responses are consumed first; a response with nothing outstanding
  // is a protocol error and falls through both terms, leaving state untouched.
  assign resp_drop = imem_resp_valid && (drop != '0);
  assign resp_fill = imem_resp_valid && (drop == '0) && (live != '0);

  assign instr_valid   = !PCReset && (count != '0);
  assign pop           = instr_valid && instr_ready;
  assign instr         = slot_instr[rd_ptr];
  assign instr_pc      = slot_pc[rd_ptr];
  assign instr_incr_pc = slot_pc[rd_ptr] + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (PCReset) begin
      pc       <= RESET_PC;
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      live     <= '0;
      drop     <= '0;
      count    <= '0;
    end else if (redirect) begin
      pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      live     <= '0;
      // Everything still outstanding becomes stale, minus a response landing
      // now (whether it was live or already stale, it is gone after this edge).
      drop     <= drop + live - CW'(resp_drop || resp_fill);
    end else begin
      if (req_fire) begin
        pc     <= pc + ADDR_W'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (resp_fill) fill_ptr <= fill_ptr + PW'(1);
      if (pop)       rd_ptr   <= rd_ptr + PW'(1);
      live  <= live + CW'(req_fire) - CW'(resp_fill);
      count <= count + CW'(resp_fill) - CW'(pop);
      drop  <= drop - CW'(resp_drop);
    end
  end

  // Slot payload needs no reset: a slot is only read once count covers it.
  always_ff @(posedge clk) begin
    if (!PCReset && !redirect) begin
      if (req_fire)  slot_pc[wr_ptr]      <= pc;
      if (resp_fill) slot_instr[fill_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit with a queue-based model:
// one queue of outstanding requests (each tagged keep/stale) that also acts as
// the in-order memory, and one queue of delivered instructions.
module tb_fetch_unit;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEPTH   = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'hFFF8;
  localparam int unsigned NCYC = 4000;

  logic               clk;
  logic               PCReset;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic [ADDR_W-1:0]  instr_incr_pc;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .PCReset         (PCReset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_incr_pc   (instr_incr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
    bit                 keep;
  } req_t;

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] data;
  } ent_t;

  req_t infl[$];
  ent_t outq[$];
  logic [ADDR_W-1:0] m_pc;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp,
                       input int unsigned cyc);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit chance(input int unsigned pct);
    return ($urandom % 100) < pct;
  endfunction

  initial begin
    bit   rst, rdr, rdy, rv, ir, exp_rv, exp_iv, credit;
    int unsigned p_rdy, p_resp, p_ir, p_rdr, p_rst, p_spur;
    req_t r;
    ent_t e;

    PCReset         = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    instr_ready     = 1'b0;
    m_pc            = RESET_PC;

    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);

      // Phases: stream with 1-cycle memory, back-pressure to full, single
      // pop, then a random mix of redirects, resets and stray responses.
      if (cyc < 60) begin
        p_rdy = 100; p_resp = 100; p_ir = 100; p_rdr = 0; p_rst = 0; p_spur = 0;
      end else if (cyc < 100) begin
        p_rdy = 100; p_resp = 100; p_ir = 0;   p_rdr = 0; p_rst = 0; p_spur = 0;
      end else if (cyc < 110) begin
        p_rdy = 100; p_resp = 100; p_ir = (cyc == 100) ? 100 : 0;
        p_rdr = 0; p_rst = 0; p_spur = 0;
      end else begin
        p_rdy = 70; p_resp = 60; p_ir = 60; p_rdr = 6; p_rst = 1; p_spur = 5;
      end

      rst = (cyc < 2) || chance(p_rst);
      rdr = chance(p_rdr);
      rdy = chance(p_rdy);
      ir  = chance(p_ir);

      PCReset        = rst;
      redirect       = rdr;
      redirect_pc    = ADDR_W'($urandom);
      imem_req_ready = rdy;
      instr_ready    = ir;
      if (infl.size() > 0) begin
        rv             = chance(p_resp);
        imem_resp_data = rv ? infl[0].data : INSTR_W'($urandom);
      end else begin
        rv             = chance(p_spur);
        imem_resp_data = INSTR_W'($urandom);
      end
      imem_resp_valid = rv;

      #1;
      credit = (outq.size() + infl.size()) < DEPTH;
      exp_rv = !rst && !rdr && credit;
      exp_iv = !rst && (outq.size() > 0);

      check("req_valid", 64'(imem_req_valid), 64'(exp_rv), cyc);
      if (!rst) check("req_addr", 64'(imem_req_addr), 64'(m_pc), cyc);
      check("instr_valid", 64'(instr_valid), 64'(exp_iv), cyc);
      if (exp_iv) begin
        check("instr", 64'(instr), 64'(outq[0].data), cyc);
        check("instr_pc", 64'(instr_pc), 64'(outq[0].pc), cyc);
        check("instr_incr_pc", 64'(instr_incr_pc), 64'(ADDR_W'(outq[0].pc + 4)), cyc);
      end

      // Model update for the coming edge.
      if (rst) begin
        infl.delete();
        outq.delete();
        m_pc = RESET_PC;
      end else begin
        if (exp_iv && ir) void'(outq.pop_front());
        if (rv && infl.size() > 0) begin
          r = infl.pop_front();
          if (r.keep) begin
            e.pc   = r.addr;
            e.data = r.data;
            outq.push_back(e);
          end
        end
        if (exp_rv && rdy) begin
          r.addr = m_pc;
          r.data = $urandom;
          r.keep = 1'b1;
          infl.push_back(r);
          m_pc = m_pc + ADDR_W'(4);
        end
        if (rdr) begin
          foreach (infl[i]) infl[i].keep = 1'b0;
          outq.delete();
          m_pc = redirect_pc & ~ADDR_W'(3);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
